// File: rtl/mem_1kb_arbiter_pkg.sv
// mem_arb_pkg: shared widths, FSM state encoding and timeout counter sizing for mem_1kb_arbiter
package mem_arb_pkg;
   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 32;
   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RELEASE} state_t;
   function automatic int cnt_w(input int timeout);
      return (timeout > 2) ? $clog2(timeout) : 1;
   endfunction
endpackage

// File: rtl/mem_1kb_arbiter_if.sv
// mem_1kb_arbiter_if: two requester ports plus the mem_1kb strobe/address/data/done bus and status.
// slave: arbiter side (takes requests and mem responses, drives acks, strobes, status).
// master: requesters and memory side.
interface mem_1kb_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic              p0_req, p0_we, p0_ack, p0_err;
   logic [ADDR_W-1:0] p0_addr;
   logic [DATA_W-1:0] p0_wdata, p0_rdata;
   logic              p1_req, p1_we, p1_ack, p1_err;
   logic [ADDR_W-1:0] p1_addr;
   logic [DATA_W-1:0] p1_wdata, p1_rdata;
   logic              mem_read, mem_write, mem_wr_done, mem_rd_done;
   logic [ADDR_W-1:0] mem_read_addr, mem_write_addr;
   logic [DATA_W-1:0] mem_wr_data, mem_rd_data;
   logic              busy, owner;
   modport slave (
      input  p0_req, p0_we, p0_addr, p0_wdata, p1_req, p1_we, p1_addr, p1_wdata,
      input  mem_rd_data, mem_wr_done, mem_rd_done,
      output p0_ack, p0_rdata, p0_err, p1_ack, p1_rdata, p1_err,
      output mem_read, mem_write, mem_read_addr, mem_write_addr, mem_wr_data, busy, owner
   );
   modport master (
      output p0_req, p0_we, p0_addr, p0_wdata, p1_req, p1_we, p1_addr, p1_wdata,
      output mem_rd_data, mem_wr_done, mem_rd_done,
      input  p0_ack, p0_rdata, p0_err, p1_ack, p1_rdata, p1_err,
      input  mem_read, mem_write, mem_read_addr, mem_write_addr, mem_wr_data, busy, owner
   );
endinterface

// File: rtl/mem_1kb_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker.
// req_i: pending requests; last_i: last granted port; grant_valid_o/grant_id_o: chosen port.
module rr_arb2 (
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic       grant_valid_o,
   output logic       grant_id_o
);
   assign grant_valid_o = |req_i;
   assign grant_id_o    = &req_i ? ~last_i : req_i[1];
endmodule

// File: rtl/mem_1kb_arbiter.sv
// mem_1kb_arbiter: round-robin arbiter/sequencer sharing one mem_1kb between two requesters.
// clk: rising-edge clock; rst: async active-low reset; bus: requester ports, mem_1kb bus, busy/owner.
module mem_1kb_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = 64
) (
   input logic clk,
   input logic rst,
   mem_1kb_arbiter_if.slave bus
);
   localparam int CW = cnt_w(TIMEOUT);
   state_t                   state_q, state_d;
   logic                     we_q, we_d, owner_q, owner_d;
   logic [ADDR_W-1:0]        addr_q, addr_d;
   logic [DATA_W-1:0]        wdata_q, wdata_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [1:0]               ack_q, ack_d, err_q, err_d;
   logic [1:0][DATA_W-1:0]   rdata_q, rdata_d;
   logic                     gnt_v, gnt_id, done, limit;
   rr_arb2 u_rr (
      .req_i        ({bus.p1_req, bus.p0_req}),
      .last_i       (owner_q),
      .grant_valid_o(gnt_v),
      .grant_id_o   (gnt_id)
   );
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      ack_d   = '0;
      err_d   = err_q;
      rdata_d = rdata_q;
      done    = we_q ? bus.mem_wr_done : bus.mem_rd_done;
      limit   = cnt_q == CW'(TIMEOUT - 1);
      case (state_q)
         ST_IDLE: if (gnt_v) begin
            state_d = ST_ISSUE;
            owner_d = gnt_id;
            we_d    = gnt_id ? bus.p1_we    : bus.p0_we;
            addr_d  = gnt_id ? bus.p1_addr  : bus.p0_addr;
            wdata_d = gnt_id ? bus.p1_wdata : bus.p0_wdata;
            cnt_d   = '0;
         end
         // a done arriving on the timeout cycle still completes cleanly
         ST_ISSUE: if (done || limit) begin
            state_d          = ST_RELEASE;
            cnt_d            = '0;
            ack_d[owner_q]   = 1'b1;
            err_d[owner_q]   = ~done;
            rdata_d[owner_q] = (done && !we_q) ? bus.mem_rd_data : '0;
         end else cnt_d = cnt_q + CW'(1);
         // hold off the next grant until mem_1kb has dropped both dones
         ST_RELEASE: if (!(bus.mem_wr_done || bus.mem_rd_done) || limit) state_d = ST_IDLE;
                     else cnt_d = cnt_q + CW'(1);
         default: state_d = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         owner_q <= 1'b1;
         ack_q   <= '0;
         err_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end
   assign bus.mem_write      = (state_q == ST_ISSUE) &&  we_q;
   assign bus.mem_read       = (state_q == ST_ISSUE) && !we_q;
   assign bus.mem_read_addr  = addr_q;
   assign bus.mem_write_addr = addr_q;
   assign bus.mem_wr_data    = wdata_q;
   assign bus.p0_ack         = ack_q[0];
   assign bus.p1_ack         = ack_q[1];
   assign bus.p0_err         = err_q[0];
   assign bus.p1_err         = err_q[1];
   assign bus.p0_rdata       = rdata_q[0];
   assign bus.p1_rdata       = rdata_q[1];
   assign bus.busy           = state_q != ST_IDLE;
   assign bus.owner          = owner_q;
endmodule

// File: tb/tb_mem_1kb_arbiter.sv
// tb_mem_1kb_arbiter: randomized directed bench with a mem_1kb model and a word-array reference model
module tb_mem_1kb_arbiter;
   localparam int TO = 8;
   typedef struct packed {logic we; logic [7:0] a; logic [31:0] d;} cmd_t;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   mem_1kb_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();
   mem_1kb_arbiter #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
   int          total = 0, passed = 0, fails = 0, viol = 0, mem_lat = 0, mcnt = 0;
   bit          withhold = 1'b0;
   int          model_owner = 1;
   logic [31:0] mem_arr [256] = '{default: 32'd0};
   logic [31:0] ref_mem [256] = '{default: 32'd0};
   logic        prev_ack0 = 1'b0, prev_ack1 = 1'b0;
   // memory model: done pulses one cycle, mem_lat cycles after the strobe is first seen
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mcnt <= 0;
         bus.mem_wr_done <= 1'b0;
         bus.mem_rd_done <= 1'b0;
         bus.mem_rd_data <= 32'd0;
      end else if ((bus.mem_read || bus.mem_write) && !withhold) begin
         mcnt <= mcnt + 1;
         if (mcnt == mem_lat) begin
            if (bus.mem_write) begin
               mem_arr[bus.mem_write_addr] <= bus.mem_wr_data;
               bus.mem_wr_done <= 1'b1;
            end else begin
               bus.mem_rd_data <= mem_arr[bus.mem_read_addr];
               bus.mem_rd_done <= 1'b1;
            end
         end else begin
            bus.mem_wr_done <= 1'b0;
            bus.mem_rd_done <= 1'b0;
         end
      end else begin
         mcnt <= 0;
         bus.mem_wr_done <= 1'b0;
         bus.mem_rd_done <= 1'b0;
      end
   end
   // protocol watcher: one strobe at a time, strobe low in ack cycles, single-cycle exclusive acks
   always @(negedge clk) if (rst) begin
      if (bus.mem_read && bus.mem_write) viol++;
      if ((bus.p0_ack || bus.p1_ack) && (bus.mem_read || bus.mem_write)) viol++;
      if (bus.p0_ack && bus.p1_ack) viol++;
      if ((bus.p0_ack && prev_ack0) || (bus.p1_ack && prev_ack1)) viol++;
      prev_ack0 <= bus.p0_ack;
      prev_ack1 <= bus.p1_ack;
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   function automatic cmd_t rnd_cmd();
      cmd_t c;
      c.we = 1'($urandom_range(0, 1));
      c.a  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
      c.d  = $urandom;
      return c;
   endfunction
   function automatic logic ack_of(input int p);
      return p ? bus.p1_ack : bus.p0_ack;
   endfunction
   task automatic drive(input int p, input bit r, input cmd_t c);
      if (p == 0) begin
         bus.p0_req = r; bus.p0_we = c.we; bus.p0_addr = c.a; bus.p0_wdata = c.d;
      end else begin
         bus.p1_req = r; bus.p1_we = c.we; bus.p1_addr = c.a; bus.p1_wdata = c.d;
      end
   endtask
   task automatic got_ack(input int p, input cmd_t c, input bit to);
      logic [31:0] exp_rd;
      exp_rd = (c.we || to) ? 32'd0 : ref_mem[c.a];
      if (c.we && !to) ref_mem[c.a] = c.d;
      chk(p ? "p1_rdata" : "p0_rdata", p ? bus.p1_rdata : bus.p0_rdata, exp_rd);
      chk(p ? "p1_err" : "p0_err", p ? bus.p1_err : bus.p0_err, to);
      model_owner = p;
   endtask
   task automatic wait_idle();
      @(negedge clk);
      for (int i = 0; i < 50 && bus.busy; i++) @(negedge clk);
      chk("idle", bus.busy, 0);
   endtask
   task automatic txn(input int p, input cmd_t c, input int lat, input bit to);
      int sc = 0, fs = -1, ai = -1, exp_sc;
      exp_sc = to ? TO : lat + 2;
      wait_idle();
      mem_lat = lat;
      withhold = to;
      drive(p, 1, c);
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (bus.mem_read || bus.mem_write) begin
            if (fs < 0) begin
               fs = i;
               chk("strobe_kind", {bus.mem_write, bus.mem_read}, c.we ? 2'b10 : 2'b01);
               chk("rd_addr", bus.mem_read_addr, c.a);
               chk("wr_addr", bus.mem_write_addr, c.a);
               if (c.we) chk("wr_data", bus.mem_wr_data, c.d);
               chk("busy", bus.busy, 1);
            end
            sc++;
         end
         if (ack_of(p)) begin
            ai = i;
            got_ack(p, c, to);
            drive(p, 0, c);
            break;
         end
      end
      chk("strobe_start", fs, 1);
      chk("strobe_len", sc, exp_sc);
      chk("ack_time", ai, exp_sc + 1);
      withhold = 1'b0;
   endtask
   task automatic pair(input cmd_t c0, input cmd_t c1, input int lat);
      int first = -1, exp_first;
      bit d0 = 0, d1 = 0;
      wait_idle();
      mem_lat = lat;
      exp_first = model_owner ? 0 : 1;
      drive(0, 1, c0);
      drive(1, 1, c1);
      for (int i = 0; i < 80 && !(d0 && d1); i++) begin
         @(negedge clk);
         if (bus.p0_ack && !d0) begin
            if (first < 0) first = 0;
            got_ack(0, c0, 0); drive(0, 0, c0); d0 = 1;
         end
         if (bus.p1_ack && !d1) begin
            if (first < 0) first = 1;
            got_ack(1, c1, 0); drive(1, 0, c1); d1 = 1;
         end
      end
      chk("pair_done", {d0, d1}, 2'b11);
      chk("pair_first", first, exp_first);
   endtask
   initial begin
      cmd_t c0, ca, cb;
      int first;
      bit ok, seen;
      drive(0, 0, '0);
      drive(1, 0, '0);
      repeat (3) @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_owner", bus.owner, 1);
      chk("rst_strobes", {bus.mem_read, bus.mem_write}, 0);
      chk("rst_acks", {bus.p0_ack, bus.p1_ack, bus.p0_err, bus.p1_err}, 0);
      chk("rst_rdata", {bus.p0_rdata, bus.p1_rdata}, 0);
      chk("rst_addr", {bus.mem_read_addr, bus.mem_write_addr, bus.mem_wr_data}, 0);
      rst = 1'b1;
      txn(0, {1'b1, 8'd0, 32'd1000}, 0, 0);
      txn(0, {1'b1, 8'd255, 32'd88889}, 1, 0);
      txn(1, {1'b0, 8'd255, 32'd0}, 2, 0);
      chk("p1_rd_255", bus.p1_rdata, 32'd88889);
      txn(0, {1'b0, 8'd0, 32'd0}, 0, 0);
      for (int i = 0; i < 4; i++) pair(rnd_cmd(), rnd_cmd(), i % 3);
      txn(1, {1'b0, 8'd7, 32'd0}, 0, 1);
      txn(1, {1'b1, 8'd7, 32'd4242}, 1, 0);
      txn(0, {1'b0, 8'd7, 32'd0}, 0, 0);
      for (int i = 0; i < 24; i++)
         txn(int'($urandom_range(0, 1)), rnd_cmd(), int'($urandom_range(0, 4)), 0);
      for (int i = 0; i < 6; i++) pair(rnd_cmd(), rnd_cmd(), int'($urandom_range(0, 3)));
      wait_idle();
      mem_lat = 3;
      c0 = rnd_cmd(); c0.we = 1'b1;
      ca = rnd_cmd(); ca.we = 1'b0;
      cb = ca; cb.a = ca.a ^ 8'h5A;
      drive(0, 1, c0);
      ok = 0;
      for (int i = 0; i < 10 && !ok; i++) begin @(negedge clk); ok = bus.mem_write; end
      chk("late_p0_strobe", ok, 1);
      drive(1, 1, ca);
      ok = 0;
      first = -1;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (bus.p1_ack) first = 1;
         if (bus.p0_ack) begin
            ok = 1;
            got_ack(0, c0, 0);
            drive(0, 0, c0);
            drive(1, 1, cb);
         end
      end
      chk("late_p0_ack", ok, 1);
      chk("late_p1_waited", first, -1);
      ok = 0;
      seen = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (bus.mem_read && !seen) begin
            seen = 1;
            chk("late_addr", bus.mem_read_addr, cb.a);
         end
         if (bus.p1_ack) begin
            ok = 1;
            got_ack(1, cb, 0);
            drive(1, 0, cb);
         end
      end
      chk("late_p1_ack", ok, 1);
      wait_idle();
      withhold = 1'b1;
      c0 = rnd_cmd(); c0.we = 1'b0;
      drive(0, 1, c0);
      ok = 0;
      for (int i = 0; i < 10 && !ok; i++) begin @(negedge clk); ok = bus.mem_read; end
      chk("arst_strobe_up", ok, 1);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_strobe", {bus.mem_read, bus.mem_write}, 0);
      chk("arst_busy", bus.busy, 0);
      chk("arst_owner", bus.owner, 1);
      chk("arst_acks", {bus.p0_ack, bus.p1_ack, bus.p0_err, bus.p1_err}, 0);
      chk("arst_rdata", {bus.p0_rdata, bus.p1_rdata}, 0);
      drive(0, 0, c0);
      withhold = 1'b0;
      model_owner = 1;
      @(negedge clk);
      rst = 1'b1;
      pair(rnd_cmd(), rnd_cmd(), 1);
      wait_idle();
      chk("protocol_viol", viol, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
